// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: operation codes, ALUOp encodings and the buffered entry.
// Widths are fixed here and used by the interface, decoder and top.
package alu_issue_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int OPCODE_LENGTH = 4;
    localparam int REG_ADDR_W    = 5;

    typedef enum logic [OPCODE_LENGTH-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_EQ  = 4'b1000,
        ALU_NE  = 4'b1001,
        ALU_ILL = 4'b1111
    } alu_op_e;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_EQ  = 3'b000;
    localparam logic [2:0] F3_NE  = 3'b001;

    typedef struct packed {
        alu_op_e                 op;
        logic                    illegal;
        logic [DATA_WIDTH-1:0]   a;
        logic [DATA_WIDTH-1:0]   b;
        logic [REG_ADDR_W-1:0]   rd;
    } entry_t;

endpackage

// File: rtl/alu_issue_if.sv
// ID-side and ALU-side handshake bundle of the issue stage.
// ALU_FWD_EN adds the register-index and forwarding-bus signals.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              in_alu_op;
    logic [2:0]              in_funct3;
    logic [6:0]              in_funct7;
    logic                    in_is_rtype;
    logic [DATA_WIDTH-1:0]   in_src_a;
    logic [DATA_WIDTH-1:0]   in_src_b;
    logic [REG_ADDR_W-1:0]   in_rd;
`ifdef ALU_FWD_EN
    logic [REG_ADDR_W-1:0]   in_rs1;
    logic [REG_ADDR_W-1:0]   in_rs2;
    logic                    fwd_valid;
    logic [REG_ADDR_W-1:0]   fwd_rd;
    logic [DATA_WIDTH-1:0]   fwd_data;
`endif
    logic                    out_valid;
    logic                    out_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]   SrcA;
    logic [DATA_WIDTH-1:0]   SrcB;
    logic [REG_ADDR_W-1:0]   out_rd;
    logic                    out_illegal;

    modport master (
`ifdef ALU_FWD_EN
        input  in_rs1, in_rs2, fwd_valid, fwd_rd, fwd_data,
`endif
        input  in_valid, in_alu_op, in_funct3, in_funct7, in_is_rtype,
        input  in_src_a, in_src_b, in_rd, out_ready,
        output in_ready, out_valid, Operation, SrcA, SrcB, out_rd, out_illegal
    );

    modport slave (
`ifdef ALU_FWD_EN
        output in_rs1, in_rs2, fwd_valid, fwd_rd, fwd_data,
`endif
        output in_valid, in_alu_op, in_funct3, in_funct7, in_is_rtype,
        output in_src_a, in_src_b, in_rd, out_ready,
        input  in_ready, out_valid, Operation, SrcA, SrcB, out_rd, out_illegal
    );

endinterface

// File: rtl/alu_issue_op_decoder.sv
// Combinational ALUOp/funct3/funct7 to ALU operation decode.
// Anything unsupported maps to ALU_ILL with illegal set.
module alu_issue_op_decoder
    import alu_issue_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_rtype,
    output alu_op_e    op,
    output logic       illegal
);

    logic f7_bad;

    always_comb begin
        op     = ALU_ILL;
        // funct7 only carries meaning for R-type; I-type immediates land there
        f7_bad = is_rtype && (funct7 != 7'd0);
        case (alu_op)
            ALUOP_MEM: op = ALU_ADD;
            ALUOP_BR: begin
                case (funct3)
                    F3_EQ:   op = ALU_EQ;
                    F3_NE:   op = ALU_NE;
                    default: op = ALU_ILL;
                endcase
            end
            ALUOP_ARITH: begin
                if (!f7_bad) begin
                    case (funct3)
                        F3_ADD:  op = ALU_ADD;
                        F3_AND:  op = ALU_AND;
                        F3_OR:   op = ALU_OR;
                        default: op = ALU_ILL;
                    endcase
                end
            end
            ALUOP_RSVD: op = ALU_ILL;
        endcase
        illegal = (op == ALU_ILL);
    end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes the ALU operation and buffers entries in a main + skid pair.
// ALU_FWD_EN enables operand replacement from the forwarding bus on accept.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    alu_issue_if.master bus
);

    entry_t                main_q, main_d;
    entry_t                skid_q, skid_d;
    entry_t                new_entry;
    logic                  main_valid_q, main_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    alu_op_e               dec_op;
    logic                  dec_illegal;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  accept;
    logic                  drain;

    alu_issue_op_decoder u_dec (
        .alu_op   (bus.in_alu_op),
        .funct3   (bus.in_funct3),
        .funct7   (bus.in_funct7),
        .is_rtype (bus.in_is_rtype),
        .op       (dec_op),
        .illegal  (dec_illegal)
    );

`ifdef ALU_FWD_EN
    always_comb begin
        src_a = bus.in_src_a;
        src_b = bus.in_src_b;
        if (bus.fwd_valid && (bus.fwd_rd != '0)) begin
            if (bus.fwd_rd == bus.in_rs1)
                src_a = bus.fwd_data;
            // I-type B is an immediate, so it never takes forwarded data
            if ((bus.fwd_rd == bus.in_rs2) && bus.in_is_rtype)
                src_b = bus.fwd_data;
        end
    end
`else
    assign src_a = bus.in_src_a;
    assign src_b = bus.in_src_b;
`endif

    always_comb begin
        new_entry.op      = dec_op;
        new_entry.illegal = dec_illegal;
        new_entry.a       = src_a;
        new_entry.b       = src_b;
        new_entry.rd      = bus.in_rd;
    end

    assign accept = bus.in_valid && !skid_valid_q;
    assign drain  = main_valid_q && bus.out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // data fields keep their last value; only the valids are killed
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.Operation   = main_q.op;
    assign bus.SrcA        = main_q.a;
    assign bus.SrcB        = main_q.b;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: accepted beats are modelled and queued, popped on each ALU transfer.
// Covers decode table, skid fill/drain, flush, async reset and (with ALU_FWD_EN) forwarding.
module tb_alu_issue;
    import alu_issue_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   failures;
    exp_t sb[$];
    bit   acc;

    alu_issue_if bus ();

    alu_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    // {alu_op, funct3, funct7, is_rtype}
    logic [12:0] vec [12] = '{
        {2'b10, 3'b000, 7'h00, 1'b1}, {2'b01, 3'b001, 7'h00, 1'b0},
        {2'b01, 3'b000, 7'h00, 1'b0}, {2'b10, 3'b000, 7'h20, 1'b1},
        {2'b10, 3'b000, 7'h20, 1'b0}, {2'b10, 3'b111, 7'h00, 1'b1},
        {2'b10, 3'b110, 7'h01, 1'b1}, {2'b10, 3'b110, 7'h00, 1'b0},
        {2'b00, 3'b101, 7'h7f, 1'b1}, {2'b11, 3'b000, 7'h00, 1'b0},
        {2'b01, 3'b100, 7'h00, 1'b0}, {2'b10, 3'b100, 7'h00, 1'b0}
    };

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [1:0] aop, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic rt);
        logic [3:0] r;
        r = 4'b1111;
        if (aop == 2'b00) r = 4'b0010;
        else if (aop == 2'b01) begin
            if (f3 == 3'b000) r = 4'b1000;
            else if (f3 == 3'b001) r = 4'b1001;
        end else if (aop == 2'b10 && !(rt && f7 != 7'd0)) begin
            if (f3 == 3'b000) r = 4'b0010;
            else if (f3 == 3'b111) r = 4'b0000;
            else if (f3 == 3'b110) r = 4'b0001;
        end
        return r;
    endfunction

    task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic rt, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.in_valid    = 1'b1;
        bus.in_alu_op   = aop;
        bus.in_funct3   = f3;
        bus.in_funct7   = f7;
        bus.in_is_rtype = rt;
        bus.in_src_a    = a;
        bus.in_src_b    = b;
        bus.in_rd       = rd;
    endtask

    task automatic cyc(output bit accepted);
        exp_t        e;
        bit          held;
        logic [45:0] snap;
        @(negedge clk);
        accepted = bus.in_valid && bus.in_ready && !flush;
        held     = bus.out_valid && !bus.out_ready;
        snap     = {bus.Operation, bus.out_illegal, bus.SrcA[15:0], bus.SrcB[15:0], bus.out_rd,
                    bus.out_valid, bus.in_ready};
        if (!flush && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("op",  {60'd0, bus.Operation}, {60'd0, e.op});
                chk("ill", {63'd0, bus.out_illegal}, {63'd0, e.ill});
                chk("a",   {32'd0, bus.SrcA}, {32'd0, e.a});
                chk("b",   {32'd0, bus.SrcB}, {32'd0, e.b});
                chk("rd",  {59'd0, bus.out_rd}, {59'd0, e.rd});
            end
        end
        if (accepted) begin
            e.op  = ref_op(bus.in_alu_op, bus.in_funct3, bus.in_funct7, bus.in_is_rtype);
            e.ill = (e.op == 4'b1111);
            e.a   = bus.in_src_a;
            e.b   = bus.in_src_b;
            e.rd  = bus.in_rd;
`ifdef ALU_FWD_EN
            if (bus.fwd_valid && bus.fwd_rd != 5'd0) begin
                if (bus.fwd_rd == bus.in_rs1) e.a = bus.fwd_data;
                if (bus.fwd_rd == bus.in_rs2 && bus.in_is_rtype) e.b = bus.fwd_data;
            end
`endif
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (held && !flush) begin
            // skid acceptance may legally drop in_ready, so only the ALU-facing fields are compared
            chk("hold", {18'd0, snap[45:1]},
                {18'd0, bus.Operation, bus.out_illegal, bus.SrcA[15:0], bus.SrcB[15:0],
                 bus.out_rd, bus.out_valid});
        end
        if (flush) sb.delete();
    endtask

    task automatic drain_all();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() > 0 || bus.out_valid); i++) cyc(acc);
        chk("sb_empty", {32'd0, sb.size()}, 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'h00, 1'b0, 32'd0, 32'd0, 5'd0);
        bus.in_valid  = 1'b0;
`ifdef ALU_FWD_EN
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.fwd_valid = 1'b0;
        bus.fwd_rd    = '0;
        bus.fwd_data  = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
        chk("rst_op",        {60'd0, bus.Operation}, 64'd0);
        chk("rst_a",         {32'd0, bus.SrcA}, 64'd0);
        chk("rst_b",         {32'd0, bus.SrcB}, 64'd0);
        chk("rst_rd",        {59'd0, bus.out_rd}, 64'd0);
        chk("rst_ill",       {63'd0, bus.out_illegal}, 64'd0);

        // single ADD beat, one-cycle latency into an empty stage
        bus.out_ready = 1'b1;
        drive(2'b10, 3'b000, 7'h00, 1'b1, 32'd5, 32'd7, 5'd9);
        cyc(acc);
        chk("lat_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("lat_op",    {60'd0, bus.Operation}, 64'h2);
        chk("lat_a",     {32'd0, bus.SrcA}, 64'd5);
        chk("lat_b",     {32'd0, bus.SrcB}, 64'd7);
        bus.in_valid = 1'b0;
        cyc(acc);

        // decode table streamed back-to-back
        for (int i = 0; i < 12; i++) begin
            drive(vec[i][12:11], vec[i][10:8], vec[i][7:1], vec[i][0],
                  32'(i * 3 + 1), ~32'(i * 3 + 1), 5'(i));
            cyc(acc);
        end
        drain_all();

        // back-to-back 1,2,3 while ALU stalls two cycles
        bus.out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'h00, 1'b0, 32'd1, 32'd0, 5'd1);
        cyc(acc);
        drive(2'b00, 3'b000, 7'h00, 1'b0, 32'd2, 32'd0, 5'd2);
        cyc(acc);
        chk("skid_in_ready", {63'd0, bus.in_ready}, 64'd0);
        drive(2'b00, 3'b000, 7'h00, 1'b0, 32'd3, 32'd0, 5'd3);
        cyc(acc);
        chk("b3_held", {63'd0, acc}, 64'd0);
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) cyc(acc);
        chk("b3_acc", {63'd0, acc}, 64'd1);
        drain_all();
        chk("idle_hold_a", {32'd0, bus.SrcA}, 64'd3);

        // flush with skid full; the concurrent input beat is dropped
        bus.out_ready = 1'b0;
        drive(2'b10, 3'b111, 7'h00, 1'b0, 32'h11, 32'h0, 5'd4);
        cyc(acc);
        drive(2'b10, 3'b110, 7'h00, 1'b0, 32'h22, 32'h0, 5'd5);
        cyc(acc);
        flush = 1'b1;
        drive(2'b00, 3'b000, 7'h00, 1'b0, 32'h33, 32'h0, 5'd6);
        cyc(acc);
        flush = 1'b0;
        chk("flush_valid",  {63'd0, bus.out_valid}, 64'd0);
        chk("flush_ready",  {63'd0, bus.in_ready}, 64'd1);
        chk("flush_hold_a", {32'd0, bus.SrcA}, 64'h11);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(acc);
            chk("flush_quiet", {63'd0, bus.out_valid}, 64'd0);
        end

        // asynchronous reset with main valid and skid full
        bus.out_ready = 1'b0;
        drive(2'b00, 3'b000, 7'h00, 1'b0, 32'h44, 32'h9, 5'd7);
        cyc(acc);
        drive(2'b01, 3'b001, 7'h00, 1'b0, 32'h55, 32'h9, 5'd8);
        cyc(acc);
        chk("pre_rst_ready", {63'd0, bus.in_ready}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("arst_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("arst_data",  {bus.SrcA, bus.SrcB}, 64'd0);
        chk("arst_op",    {58'd0, bus.Operation, bus.out_illegal, bus.out_rd == 5'd0}, 64'd1);
        sb.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        cyc(acc);
        chk("post_rst_quiet", {63'd0, bus.out_valid}, 64'd0);

`ifdef ALU_FWD_EN
        drive(2'b10, 3'b000, 7'h00, 1'b1, 32'h10, 32'h20, 5'd1);
        bus.in_rs1 = 5'd3; bus.in_rs2 = 5'd4;
        bus.fwd_valid = 1'b1; bus.fwd_rd = 5'd3; bus.fwd_data = 32'hAA;
        cyc(acc);
        chk("fwd_a", {32'd0, bus.SrcA}, 64'hAA);
        chk("fwd_b", {32'd0, bus.SrcB}, 64'h20);
        drive(2'b10, 3'b000, 7'h00, 1'b1, 32'h10, 32'h20, 5'd1);
        bus.in_rs1 = 5'd0; bus.fwd_rd = 5'd0;
        cyc(acc);
        chk("fwd_rd0_a", {32'd0, bus.SrcA}, 64'h10);
        drive(2'b10, 3'b000, 7'h00, 1'b0, 32'h10, 32'h20, 5'd1);
        bus.in_rs2 = 5'd6; bus.fwd_rd = 5'd6;
        cyc(acc);
        chk("fwd_itype_b", {32'd0, bus.SrcB}, 64'h20);
        drain_all();
`endif

        // random valid/ready traffic
        for (int i = 0; i < 60; i++) begin
            drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20, 1'($urandom_range(0, 1)),
                  32'($urandom), 32'($urandom), 5'($urandom_range(0, 31)));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_FWD_EN
            bus.in_rs1    = 5'($urandom_range(0, 3));
            bus.in_rs2    = 5'($urandom_range(0, 3));
            bus.fwd_valid = 1'($urandom_range(0, 1));
            bus.fwd_rd    = 5'($urandom_range(0, 3));
            bus.fwd_data  = 32'($urandom);
`endif
            cyc(acc);
        end
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
